// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache controller.
//   state_t      controller FSM states
//   OFFSET_W / INDEX_W / TAG_W  address split for the default geometry
//   tag_entry_t  per-way tag store entry {valid, dirty, tag}
// The tag field is sized to the full default address width and holds the tag
// right-aligned, so one entry type serves any geometry with ADDR_W <= 32.
package cache_pkg;

  localparam int unsigned WAYS_DEF       = 4;
  localparam int unsigned SETS_DEF       = 8;
  localparam int unsigned LINE_BYTES_DEF = 8;
  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned DATA_W_DEF     = 8;

  localparam int unsigned OFFSET_W = $clog2(LINE_BYTES_DEF);
  localparam int unsigned INDEX_W  = $clog2(SETS_DEF);
  localparam int unsigned TAG_W    = ADDR_W_DEF - INDEX_W - OFFSET_W;
  localparam int unsigned TAG_E_W  = ADDR_W_DEF;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    FILL,
    RESP
  } state_t;

  typedef struct packed {
    logic               valid;
    logic               dirty;
    logic [TAG_E_W-1:0] tag;
  } tag_entry_t;

endpackage

// File: rtl/lru_tracker.sv
// True-LRU bookkeeping, one age per way per set (0 = MRU, WAYS-1 = LRU).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (way i gets age i)
//   set         set being accessed
//   way         way being touched
//   touch       make 'way' MRU in 'set'; younger ways age by one
//   lru_way     least recently used way of 'set' (combinational)
module lru_tracker
  import cache_pkg::*;
#(
  parameter int unsigned WAYS = WAYS_DEF,
  parameter int unsigned SETS = SETS_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [$clog2(SETS)-1:0] set,
  input  logic [$clog2(WAYS)-1:0] way,
  input  logic                    touch,
  output logic [$clog2(WAYS)-1:0] lru_way
);

  localparam int unsigned WW = $clog2(WAYS);

  logic [WW-1:0] age [SETS][WAYS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          age[s][w] <= WW'(w);
        end
      end
    end else if (touch) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (WW'(w) == way) begin
          age[set][w] <= '0;
        end else if (age[set][w] < age[set][way]) begin
          age[set][w] <= age[set][w] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    lru_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (age[set][w] == WW'(WAYS - 1)) begin
        lru_way = WW'(w);
      end
    end
  end

endmodule

// File: rtl/set_assoc_cache_ctrl.sv
// N-way set-associative, write-back, write-allocate byte cache controller.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             core request handshake (ready only in IDLE)
//   req_addr/req_write/req_wdata    request address, store flag, store byte
//   resp_valid/resp_rdata           one-cycle completion pulse and byte
//   mem_req_valid/ready/write       memory beat handshake, 1 = writeback beat
//   mem_req_addr/mem_req_wdata      beat address and writeback byte
//   mem_resp_valid/mem_resp_rdata   refill byte return
// Optional: define CACHE_STATS_EN to add saturating stat_hits, stat_misses,
// stat_writebacks counters.
module set_assoc_cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned WAYS       = WAYS_DEF,
  parameter int unsigned SETS       = SETS_DEF,
  parameter int unsigned LINE_BYTES = LINE_BYTES_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
  output logic [31:0]       stat_writebacks
`endif
);

  localparam int unsigned OW = $clog2(LINE_BYTES);
  localparam int unsigned IW = $clog2(SETS);
  localparam int unsigned TW = ADDR_W - IW - OW;
  localparam int unsigned WW = $clog2(WAYS);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [WW-1:0]     way_q;
  logic [OW-1:0]     beat;
  logic              fill_wait;

  tag_entry_t        tags [SETS][WAYS];
  logic [DATA_W-1:0] data [SETS][WAYS][LINE_BYTES];

  logic [IW-1:0]      idx;
  logic [OW-1:0]      off;
  logic [TW-1:0]      tag_q;
  logic [TAG_E_W-1:0] tag_ext;
  logic [TW-1:0]      old_tag;
  logic [OW-1:0]      beat_nxt;

  assign idx      = addr_q[OW +: IW];
  assign off      = addr_q[OW-1:0];
  assign tag_q    = addr_q[ADDR_W-1 -: TW];
  assign tag_ext  = TAG_E_W'(tag_q);
  assign old_tag  = tags[idx][way_q].tag[TW-1:0];
  assign beat_nxt = beat + 1'b1;

  logic          hit;
  logic [WW-1:0] hit_way;
  logic          inv_found;
  logic [WW-1:0] inv_way;
  logic [WW-1:0] lru_way;
  logic [WW-1:0] victim;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (tags[idx][w].valid && (tags[idx][w].tag == tag_ext) && !hit) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (!tags[idx][w].valid && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WW'(w);
      end
    end
    victim = inv_found ? inv_way : lru_way;
  end

  // Hits and fills both pass through RESP, so touching there covers both.
  lru_tracker #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .clk     (clk),
    .rst_n   (rst_n),
    .set     (idx),
    .way     (way_q),
    .touch   (state == RESP),
    .lru_way (lru_way)
  );

  // Data array kept out of the reset domain so it can map onto RAM.
  logic fill_we;
  logic store_we;
  assign fill_we  = (state == FILL) && fill_wait && mem_resp_valid;
  assign store_we = (state == RESP) && write_q;

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data[idx][way_q][beat] <= mem_resp_rdata;
    end else if (store_we) begin
      data[idx][way_q][off] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      req_ready     <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      mem_req_valid <= 1'b0;
      mem_req_write <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      addr_q        <= '0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      way_q         <= '0;
      beat          <= '0;
      fill_wait     <= 1'b0;
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          tags[s][w] <= '0;
        end
      end
`ifdef CACHE_STATS_EN
      stat_hits       <= '0;
      stat_misses     <= '0;
      stat_writebacks <= '0;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            write_q   <= req_write;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          beat      <= '0;
          fill_wait <= 1'b0;
          if (hit) begin
            way_q <= hit_way;
            state <= RESP;
`ifdef CACHE_STATS_EN
            if (stat_hits != '1) stat_hits <= stat_hits + 1'b1;
`endif
          end else begin
            way_q         <= victim;
            mem_req_valid <= 1'b1;
`ifdef CACHE_STATS_EN
            if (stat_misses != '1) stat_misses <= stat_misses + 1'b1;
`endif
            if (tags[idx][victim].valid && tags[idx][victim].dirty) begin
              state         <= WB;
              mem_req_write <= 1'b1;
              mem_req_addr  <= {tags[idx][victim].tag[TW-1:0], idx, OW'(0)};
              mem_req_wdata <= data[idx][victim][0];
`ifdef CACHE_STATS_EN
              if (stat_writebacks != '1) stat_writebacks <= stat_writebacks + 1'b1;
`endif
            end else begin
              state         <= FILL;
              mem_req_write <= 1'b0;
              mem_req_addr  <= {tag_q, idx, OW'(0)};
              mem_req_wdata <= '0;
            end
          end
        end
        WB: begin
          if (mem_req_ready) begin
            if (beat == OW'(LINE_BYTES - 1)) begin
              // Last writeback beat accepted: first refill read goes out next.
              state         <= FILL;
              beat          <= '0;
              fill_wait     <= 1'b0;
              mem_req_write <= 1'b0;
              mem_req_addr  <= {tag_q, idx, OW'(0)};
              mem_req_wdata <= '0;
            end else begin
              beat          <= beat_nxt;
              mem_req_addr  <= {old_tag, idx, beat_nxt};
              mem_req_wdata <= data[idx][way_q][beat_nxt];
            end
          end
        end
        FILL: begin
          if (!fill_wait) begin
            if (mem_req_ready) begin
              mem_req_valid <= 1'b0;
              fill_wait     <= 1'b1;
            end
          end else if (mem_resp_valid) begin
            fill_wait <= 1'b0;
            if (beat == OW'(LINE_BYTES - 1)) begin
              tags[idx][way_q] <= '{valid: 1'b1, dirty: 1'b0, tag: tag_ext};
              state            <= RESP;
            end else begin
              beat          <= beat_nxt;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {tag_q, idx, beat_nxt};
            end
          end
        end
        RESP: begin
          resp_valid <= 1'b1;
          resp_rdata <= write_q ? wdata_q : data[idx][way_q][off];
          if (write_q) begin
            tags[idx][way_q].dirty <= 1'b1;
          end
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Directed bench for set_assoc_cache_ctrl with a byte-wide memory model.
// Memory content at an unwritten address a is a[7:0] ^ a[15:8] ^ 8'h3C.
module tb_set_assoc_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [7:0]  req_wdata;
  logic        resp_valid;
  logic [7:0]  resp_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_write;
  logic [31:0] mem_req_addr;
  logic [7:0]  mem_req_wdata;
  logic        mem_resp_valid;
  logic [7:0]  mem_resp_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
  logic [31:0] stat_writebacks;
`endif

  always #5 clk = ~clk;

  set_assoc_cache_ctrl #(
    .WAYS       (4),
    .SETS       (8),
    .LINE_BYTES (8),
    .ADDR_W     (32),
    .DATA_W     (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_write      (req_write),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_write  (mem_req_write),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
`ifdef CACHE_STATS_EN
    ,
    .stat_hits       (stat_hits),
    .stat_misses     (stat_misses),
    .stat_writebacks (stat_writebacks)
`endif
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [7:0]  data;
  } beat_t;

  beat_t       log_q[$];
  logic [7:0]  mem [int unsigned];
  logic        pend = 1'b0;
  logic [31:0] paddr;
  logic        ready_en;

  assign mem_req_ready = ready_en;

  function automatic logic [7:0] memval(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] memrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return memval(a);
  endfunction

  // Memory side: log every accepted beat, answer reads one cycle later.
  always @(posedge clk) begin
    if (mem_req_valid && mem_req_ready) begin
      log_q.push_back('{mem_req_addr, mem_req_write, mem_req_wdata});
      if (mem_req_write) begin
        mem[mem_req_addr] = mem_req_wdata;
      end else begin
        pend  = 1'b1;
        paddr = mem_req_addr;
      end
    end
  end

  initial begin
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
  end

  always @(negedge clk) begin
    if (pend) begin
      mem_resp_valid = 1'b1;
      mem_resp_rdata = memrd(paddr);
      pend = 1'b0;
    end else begin
      mem_resp_valid = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [7:0] d);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    req_wdata = d;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("handshake", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_req(input logic [31:0] a, input logic w, input logic [7:0] d,
                        output logic [7:0] rd, output int lat);
    issue(a, w, d);
    lat = 0;
    while (!resp_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk("resp_seen", {31'b0, resp_valid}, 32'd1);
    rd = resp_rdata;
  endtask

  task automatic chk_reads(input string tag, input logic [31:0] base, input int start);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_addr"}, log_q[start+i].addr, base + 32'(i));
      chk({tag, "_wr"}, {31'b0, log_q[start+i].wr}, 32'd0);
    end
  endtask

  logic [7:0] rd;
  int         lat;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_write = 1'b0;
    req_wdata = '0;
    ready_en  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_resp_rdata", {24'b0, resp_rdata}, 32'h0);
    rst_n = 1'b1;

    // 1: cold load
    log_q.delete();
    do_req(32'h40, 1'b0, 8'h00, rd, lat);
    chk("t1_rdata", {24'b0, rd}, 32'h7C);
    chk("t1_beats", log_q.size(), 32'd8);
    chk_reads("t1", 32'h40, 0);

    // 2: hit latency, no memory traffic, single-cycle pulse
    log_q.delete();
    do_req(32'h41, 1'b0, 8'h00, rd, lat);
    chk("t2_lat", lat, 32'd2);
    chk("t2_rdata", {24'b0, rd}, 32'h7D);
    chk("t2_beats", log_q.size(), 32'd0);
    @(negedge clk);
    chk("t2_pulse_width", {31'b0, resp_valid}, 32'd0);

    // 3: store hit, fill set 0, then dirty LRU victim written back
    do_req(32'h40, 1'b1, 8'hA5, rd, lat);
    chk("t3_store_lat", lat, 32'd2);
    chk("t3_store_rdata", {24'b0, rd}, 32'hA5);
    do_req(32'h80, 1'b0, 8'h00, rd, lat);
    do_req(32'hC0, 1'b0, 8'h00, rd, lat);
    do_req(32'h100, 1'b0, 8'h00, rd, lat);
    log_q.delete();
    do_req(32'h140, 1'b0, 8'h00, rd, lat);
    chk("t3_beats", log_q.size(), 32'd16);
    chk("t3_wb0_data", {24'b0, log_q[0].data}, 32'hA5);
    for (int i = 0; i < 8; i++) begin
      chk("t3_wb_addr", log_q[i].addr, 32'h40 + 32'(i));
      chk("t3_wb_wr", {31'b0, log_q[i].wr}, 32'd1);
      if (i > 0) chk("t3_wb_data", {24'b0, log_q[i].data}, {24'b0, memval(32'h40 + 32'(i))});
    end
    chk_reads("t3_rd", 32'h140, 8);
    chk("t3_rdata", {24'b0, rd}, 32'h7D);

    // 4: hit way0 of full set, next miss must evict way1
    log_q.delete();
    do_req(32'h140, 1'b0, 8'h00, rd, lat);
    chk("t4_hit_lat", lat, 32'd2);
    chk("t4_hit_beats", log_q.size(), 32'd0);
    log_q.delete();
    do_req(32'h180, 1'b0, 8'h00, rd, lat);
    chk("t4_miss_beats", log_q.size(), 32'd8);
    chk_reads("t4_miss", 32'h180, 0);
    chk("t4_miss_rdata", {24'b0, rd}, 32'hBD);
    log_q.delete();
    do_req(32'h140, 1'b0, 8'h00, rd, lat);
    chk("t4_way0_kept", log_q.size(), 32'd0);
    log_q.delete();
    do_req(32'h80, 1'b0, 8'h00, rd, lat);
    chk("t4_way1_evicted", log_q.size(), 32'd8);
    chk("t4_reload_rdata", {24'b0, rd}, 32'hBC);

    // 5: writeback stalled for 5 cycles on beat 3
    do_req(32'h48, 1'b1, 8'hB7, rd, lat);
    do_req(32'h88, 1'b0, 8'h00, rd, lat);
    do_req(32'hC8, 1'b0, 8'h00, rd, lat);
    do_req(32'h108, 1'b0, 8'h00, rd, lat);
    log_q.delete();
    fork
      do_req(32'h148, 1'b0, 8'h00, rd, lat);
      begin
        int n;
        n = 0;
        while (log_q.size() < 3 && n < 500) begin
          @(negedge clk);
          n++;
        end
        chk("t5_stall_reached", log_q.size(), 32'd3);
        ready_en = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("t5_stall_valid", {31'b0, mem_req_valid}, 32'd1);
          chk("t5_stall_addr", mem_req_addr, 32'h4B);
          chk("t5_stall_wdata", {24'b0, mem_req_wdata}, 32'h77);
        end
        ready_en = 1'b1;
      end
    join
    chk("t5_beats", log_q.size(), 32'd16);
    chk("t5_wb0_data", {24'b0, log_q[0].data}, 32'hB7);
    for (int i = 0; i < 8; i++) begin
      chk("t5_wb_addr", log_q[i].addr, 32'h48 + 32'(i));
      chk("t5_wb_wr", {31'b0, log_q[i].wr}, 32'd1);
      if (i > 0) chk("t5_wb_data", {24'b0, log_q[i].data}, {24'b0, memval(32'h48 + 32'(i))});
    end
    chk_reads("t5_rd", 32'h148, 8);
    chk("t5_rdata", {24'b0, rd}, 32'h75);

    // 6: reset in the middle of a refill
    log_q.delete();
    issue(32'h200, 1'b0, 8'h00);
    begin
      int n;
      n = 0;
      while (log_q.size() < 3 && n < 500) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t6_fill_reached", log_q.size(), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("t6_rst_req_ready", {31'b0, req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    log_q.delete();
    do_req(32'h200, 1'b0, 8'h00, rd, lat);
    chk("t6_remiss_beats", log_q.size(), 32'd8);
    chk_reads("t6_rd", 32'h200, 0);
    chk("t6_rdata", {24'b0, rd}, 32'h3E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
